parking_gate_controller: RTL and testbench
==========================================

# parking_gate_controller

Consumes the one-cycle `entry_detected` / `exit_detected` pulses produced by the gate sensor front-end. It maintains the lot occupancy count and drives the entry and exit barrier gates. Each gate is a timed open/close state machine. Entry is refused while the lot is full. The block sits between the sensor edge-detection stage and the barrier actuators and status display.

## Interface
Parameters:
- `CAPACITY`, 8, number of parking spaces; legal range 1..(2^CNT_W − 1)
- `CNT_W`, 4, width of the occupancy counter
- `OPEN_CYCLES`, 50, clock cycles a gate stays open after its last accepted pulse; must be ≥ 1

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `entry_detected`  in  1  one-cycle pulse: car present at entry gate
- `exit_detected`  in  1  one-cycle pulse: car leaving through exit gate
- `entry_gate_open`  out  1  registered; 1 = entry barrier raised
- `exit_gate_open`  out  1  registered; 1 = exit barrier raised
- `car_count`  out  CNT_W  registered occupancy, 0..CAPACITY
- `full`  out  1  `car_count == CAPACITY`
- `empty`  out  1  `car_count == 0`
- `entry_denied`  out  1  registered one-cycle pulse: entry refused because lot full
- `exit_ignored`  out  1  registered one-cycle pulse: exit pulse received with `car_count == 0`

## Operation
- Reset (async assert, `reset` = 0) forces the following values:
  - `car_count` = 0, `entry_gate_open` = 0, `exit_gate_open` = 0
  - `entry_denied` = 0, `exit_ignored` = 0
  - both gate FSMs in CLOSED, both timers 0
  - `full` = 0, `empty` = 1
- Reset asserted mid-operation aborts any open gate immediately and discards the count.
- Accept rules are evaluated on each rising edge against the registered `car_count` (pre-update value):
  - Entry accepted iff `entry_detected` = 1 and `car_count < CAPACITY`.
  - Entry refused iff `entry_detected` = 1 and `car_count == CAPACITY`. `entry_denied` pulses for 1 cycle; count and entry gate are unchanged.
  - Exit accepted iff `exit_detected` = 1 and `car_count > 0`.
  - Exit refused iff `exit_detected` = 1 and `car_count == 0`. `exit_ignored` pulses for 1 cycle; count and exit gate are unchanged.
- Count update:
  - accepted entry only: +1
  - accepted exit only: −1
  - both accepted in the same cycle: unchanged
- Count never wraps. It is saturated by the accept rules, not by arithmetic.
- Simultaneous entry and exit at full: entry is refused (decision uses the pre-update count), exit is accepted, count becomes CAPACITY−1.
- Gate FSM (one per gate, identical), states CLOSED and OPEN:
  - CLOSED → OPEN on an accepted pulse; timer loaded with OPEN_CYCLES−1.
  - In OPEN, an accepted pulse reloads the timer with OPEN_CYCLES−1 (retrigger for back-to-back cars) and still updates the count.
  - In OPEN, no pulse: the timer decrements. OPEN → CLOSED on the edge where the timer is 0 and no accepted pulse arrives.
  - `*_gate_open` = (state == OPEN).
- The two gates are fully independent apart from sharing `car_count`.

## Timing
- Latency is one edge. A pulse high in cycle N is sampled at the edge ending cycle N, and all outputs update at that same edge.
- With no retrigger, a gate stays open for exactly OPEN_CYCLES cycles after the accepting edge.
- A retrigger at the edge k cycles into the open window extends the open time to OPEN_CYCLES cycles after that edge. The gate never drops low between the two pulses.
- `entry_denied` and `exit_ignored` are high for exactly one cycle per refused pulse. Refusals on consecutive cycles give consecutive pulses.
- `full` and `empty` are derived from the registered `car_count`, so they change on the same edge as the count.
- Inputs are assumed synchronous to `clk` and at most one cycle wide per event.

## Test plan
Parameters for all scenarios: CAPACITY = 2, OPEN_CYCLES = 4.
- **Reset:** hold `reset` = 0 mid-open, then release → all outputs 0 except `empty` = 1; no gate activity until the next pulse.
- **Single entry:** one `entry_detected` pulse → `car_count` 0→1 at the next edge, `entry_gate_open` high for exactly 4 cycles, `empty` falls.
- **Retrigger:** entry pulses 2 cycles apart → count 0→2, `full` = 1, gate continuously high until 4 cycles after the second pulse.
- **Full refusal:** third entry pulse at count 2 → `entry_denied` high 1 cycle, count stays 2, entry gate does not reopen.
- **Simultaneous at full:** entry and exit pulses in the same cycle at count 2 → `entry_denied` = 1, `exit_gate_open` rises, count = 1, `full` = 0.
- **Empty exit:** exit pulse at count 0 → `exit_ignored` high 1 cycle, count stays 0, exit gate stays closed.

Source files
------------

// File: rtl/parking_gate_controller.sv
// Parking lot occupancy counter with two independently timed barrier gates.
// Entry is refused at capacity; exits are ignored when the lot is empty.
module parking_gate_timer #(
    parameter int OPEN_CYCLES = 50,
    parameter int TW          = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic gate_open
);

    typedef enum logic {CLOSED = 1'b0, OPEN = 1'b1} gate_state_e;

    localparam logic [TW-1:0] RELOAD = TW'(OPEN_CYCLES - 1);

    gate_state_e   state_q;
    gate_state_e   state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLOSED;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Any accepted pulse (re)arms the full open window.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            CLOSED: begin
                if (trigger) begin
                    state_d = OPEN;
                    timer_d = RELOAD;
                end
            end
            OPEN: begin
                if (trigger) begin
                    timer_d = RELOAD;
                end else if (timer_q == '0) begin
                    state_d = CLOSED;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                state_d = CLOSED;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        gate_open = (state_q == OPEN);
    end

endmodule

module parking_gate_controller #(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int OPEN_CYCLES = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_detected,
    input  logic             exit_detected,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic [CNT_W-1:0] car_count,
    output logic             full,
    output logic             empty,
    output logic             entry_denied,
    output logic             exit_ignored
);

    localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

    logic             entry_ok;
    logic             exit_ok;
    logic [CNT_W-1:0] count_d;

    // Decisions use the registered (pre-update) count.
    assign entry_ok = entry_detected && (car_count < CAP);
    assign exit_ok  = exit_detected && (car_count != '0);

    always_comb begin
        count_d = car_count;
        if (entry_ok && !exit_ok) begin
            count_d = car_count + 1'b1;
        end else if (exit_ok && !entry_ok) begin
            count_d = car_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_count    <= '0;
            entry_denied <= 1'b0;
            exit_ignored <= 1'b0;
        end else begin
            car_count    <= count_d;
            entry_denied <= entry_detected && !entry_ok;
            exit_ignored <= exit_detected && !exit_ok;
        end
    end

    assign full  = (car_count == CAP);
    assign empty = (car_count == '0);

    parking_gate_timer #(
        .OPEN_CYCLES(OPEN_CYCLES),
        .TW         (TW)
    ) u_entry_gate (
        .clk      (clk),
        .reset    (reset),
        .trigger  (entry_ok),
        .gate_open(entry_gate_open)
    );

    parking_gate_timer #(
        .OPEN_CYCLES(OPEN_CYCLES),
        .TW         (TW)
    ) u_exit_gate (
        .clk      (clk),
        .reset    (reset),
        .trigger  (exit_ok),
        .gate_open(exit_gate_open)
    );

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: occupancy/gate model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_parking_gate_controller;

    localparam int CAP   = 2;
    localparam int CW    = 4;
    localparam int OC    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          entry_detected = 1'b0;
    logic          exit_detected = 1'b0;
    logic          entry_gate_open;
    logic          exit_gate_open;
    logic [CW-1:0] car_count;
    logic          full;
    logic          empty;
    logic          entry_denied;
    logic          exit_ignored;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: occupancy and cycles of open window remaining per gate.
    int m_count = 0;
    int m_erem  = 0;
    int m_xrem  = 0;
    bit m_den   = 1'b0;
    bit m_ign   = 1'b0;

    parking_gate_controller #(
        .CAPACITY   (CAP),
        .CNT_W      (CW),
        .OPEN_CYCLES(OC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry_detected (entry_detected),
        .exit_detected  (exit_detected),
        .entry_gate_open(entry_gate_open),
        .exit_gate_open (exit_gate_open),
        .car_count      (car_count),
        .full           (full),
        .empty          (empty),
        .entry_denied   (entry_denied),
        .exit_ignored   (exit_ignored)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count = 0;
            m_erem  = 0;
            m_xrem  = 0;
            m_den   = 1'b0;
            m_ign   = 1'b0;
        end else begin
            bit ea;
            bit xa;
            ea = entry_detected && (m_count < CAP);
            xa = exit_detected && (m_count > 0);
            m_den = entry_detected && !ea;
            m_ign = exit_detected && !xa;
            m_count = m_count + int'(ea) - int'(xa);
            m_erem = ea ? OC : ((m_erem > 0) ? m_erem - 1 : 0);
            m_xrem = xa ? OC : ((m_xrem > 0) ? m_xrem - 1 : 0);
        end
    end

    always @(negedge clk) begin
        chk("model_count", int'(car_count), m_count);
        chk("model_full", int'(full), int'(m_count == CAP));
        chk("model_empty", int'(empty), int'(m_count == 0));
        chk("model_entry_gate", int'(entry_gate_open), int'(m_erem > 0));
        chk("model_exit_gate", int'(exit_gate_open), int'(m_xrem > 0));
        chk("model_denied", int'(entry_denied), int'(m_den));
        chk("model_ignored", int'(exit_ignored), int'(m_ign));
    end

    task automatic step(input bit e, input bit x);
        entry_detected = e;
        exit_detected  = x;
        @(posedge clk);
        #1;
        entry_detected = 1'b0;
        exit_detected  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(1);
        chk("rst_count", int'(car_count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);

        // Single entry: open for exactly OC cycles
        step(1, 0);
        chk("single_count", int'(car_count), 1);
        chk("single_gate", int'(entry_gate_open), 1);
        chk("single_empty", int'(empty), 0);
        idle(3);
        chk("single_gate_last", int'(entry_gate_open), 1);
        idle(1);
        chk("single_gate_closed", int'(entry_gate_open), 0);

        step(0, 1);
        chk("exit_count", int'(car_count), 0);
        chk("exit_gate", int'(exit_gate_open), 1);
        idle(5);

        // Retrigger two cycles apart
        step(1, 0);
        idle(1);
        step(1, 0);
        chk("retrig_count", int'(car_count), 2);
        chk("retrig_full", int'(full), 1);
        idle(3);
        chk("retrig_gate_last", int'(entry_gate_open), 1);
        idle(1);
        chk("retrig_gate_closed", int'(entry_gate_open), 0);

        // Full refusal, then back-to-back refusals
        step(1, 0);
        chk("deny_pulse", int'(entry_denied), 1);
        chk("deny_count", int'(car_count), 2);
        chk("deny_gate", int'(entry_gate_open), 0);
        idle(1);
        chk("deny_drop", int'(entry_denied), 0);
        step(1, 0);
        step(1, 0);
        chk("deny_consec", int'(entry_denied), 1);
        idle(1);

        // Simultaneous at full
        step(1, 1);
        chk("sim_denied", int'(entry_denied), 1);
        chk("sim_exit_gate", int'(exit_gate_open), 1);
        chk("sim_count", int'(car_count), 1);
        chk("sim_full", int'(full), 0);
        idle(5);

        // Both accepted at count 1: count holds, both gates open
        step(1, 1);
        chk("both_count", int'(car_count), 1);
        chk("both_entry_gate", int'(entry_gate_open), 1);
        chk("both_exit_gate", int'(exit_gate_open), 1);
        idle(5);

        step(0, 1);
        idle(5);

        // Exit at empty
        step(0, 1);
        chk("ign_pulse", int'(exit_ignored), 1);
        chk("ign_count", int'(car_count), 0);
        chk("ign_gate", int'(exit_gate_open), 0);
        idle(1);
        chk("ign_drop", int'(exit_ignored), 0);

        // Reset mid-open
        step(1, 0);
        idle(1);
        reset = 1'b0;
        #2;
        chk("midrst_gate", int'(entry_gate_open), 0);
        chk("midrst_count", int'(car_count), 0);
        idle(2);
        reset = 1'b1;
        idle(6);
        chk("post_rst_gate", int'(entry_gate_open), 0);
        chk("post_rst_empty", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
